// File: rtl/shift_sequencer_pkg.sv
// Shared types and helpers for the shift-register sequencer:
// the FSM state encoding and the shift-length clamp rule.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // A zero or oversized request means "shift the whole register".
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned nr_of_stages);
    int unsigned eff;
    if (len == 32'd0 || len > nr_of_stages) begin
      eff = nr_of_stages;
    end else begin
      eff = len;
    end
    return eff;
  endfunction

endpackage

// File: rtl/shift_sequencer_counter.sv
// Loadable up-counter used to count shift ticks. o_terminal flags that the
// next enabled increment reaches i_terminal; the count never passes it.
module seq_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             s_clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_value,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_terminal,
  output logic             o_terminal
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  // Count register: load has priority, increments stop at the terminal value.
  always_ff @(posedge s_clock or posedge reset) begin
    if (reset) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable && (r_count != i_terminal)) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign o_terminal = ((r_count + CNT_ONE) == i_terminal);

endmodule

// File: rtl/shift_sequencer.sv
// Sequencer for an external shift register: accepts a parallel word, loads it,
// shifts it a configurable number of ticks and returns the settled result.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int NR_OF_STAGES = 8,
  parameter int LEN_W        = 6
) (
  input  logic                    s_clock,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NR_OF_STAGES-1:0] in_data,
  input  logic [LEN_W-1:0]        cfg_len,
  output logic                    sr_parLoad,
  output logic                    sr_shiftEnable,
  output logic [NR_OF_STAGES-1:0] sr_d,
  input  logic [NR_OF_STAGES-1:0] sr_q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NR_OF_STAGES-1:0] out_data,
  output logic                    busy
);

  localparam int CNT_W = $clog2(NR_OF_STAGES + 1);

  seq_state_e              r_state;
  seq_state_e              w_state_next;
  logic                    r_par_load;
  logic                    r_shift_en;
  logic                    r_busy;
  logic                    r_in_ready;
  logic [NR_OF_STAGES-1:0] r_sr_d;
  logic [CNT_W-1:0]        r_len;
  logic [NR_OF_STAGES-1:0] r_out_data;
  logic                    r_out_valid;
  logic [CNT_W-1:0]        w_len_eff;
  logic                    w_accept;
  logic                    w_cnt_load;
  logic                    w_cnt_enable;
  logic                    w_terminal;

  assign w_len_eff = CNT_W'(clamp_len(32'(cfg_len), 32'(NR_OF_STAGES)));

  seq_bit_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .s_clock     (s_clock),
    .reset       (reset),
    .i_load      (w_cnt_load),
    .i_load_value({CNT_W{1'b0}}),
    .i_enable    (w_cnt_enable),
    .i_terminal  (r_len),
    .o_terminal  (w_terminal)
  );

  // Next-state logic; every transition is qualified by tick.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_enable = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tick && in_valid && r_in_ready) begin
          w_accept     = 1'b1;
          w_state_next = ST_LOAD;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (tick) begin
          w_cnt_load   = 1'b1;
          w_state_next = ST_SHIFT;
        end else begin
          w_state_next = ST_LOAD;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          w_cnt_enable = 1'b1;
          w_state_next = w_terminal ? ST_DONE : ST_SHIFT;
        end else begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (tick && r_out_valid && out_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register; controls are decoded from the next state so they are
  // registered and change only together with the state.
  always_ff @(posedge s_clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_par_load <= 1'b0;
      r_shift_en <= 1'b0;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_par_load <= (w_state_next == ST_LOAD);
      r_shift_en <= (w_state_next == ST_SHIFT);
      r_busy     <= (w_state_next != ST_IDLE);
      r_in_ready <= (w_state_next == ST_IDLE);
    end
  end

  // Transaction parameters captured at acceptance.
  always_ff @(posedge s_clock or posedge reset) begin
    if (reset) begin
      r_sr_d <= {NR_OF_STAGES{1'b0}};
      r_len  <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_sr_d <= in_data;
      r_len  <= w_len_eff;
    end
  end

  // The first DONE tick lets the last shift settle before sr_q is captured.
  always_ff @(posedge s_clock or posedge reset) begin
    if (reset) begin
      r_out_data  <= {NR_OF_STAGES{1'b0}};
      r_out_valid <= 1'b0;
    end else if ((r_state == ST_DONE) && tick) begin
      if (!r_out_valid) begin
        r_out_data  <= sr_q;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready       = r_in_ready;
  assign busy           = r_busy;
  assign sr_parLoad     = r_par_load;
  assign sr_shiftEnable = r_shift_en;
  assign sr_d           = r_sr_d;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;

endmodule
